// File: rtl/position_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : position_arbiter
// Brief    : Debounces five hand/seat position buttons and grants one of them
//            with a sticky, lowest-index-first rule. It tracks how long the
//            granted position has been held and raises an alert (optionally
//            with a buzzer) once the dwell time reaches its limit.
// Config   : POSITION_ARBITER_BUZZER_EN - when defined, builds the buzzer
//            toggle logic. When undefined, buzzer is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module position_arbiter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 50000,
    parameter int DWELL_LIMIT     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drops_button,
    input  logic       hoods_button,
    input  logic       tops_button,
    input  logic       bar_button,
    input  logic       seat_button,
    output logic [4:0] BOARD_LEDs,
    output logic       pos_change,
    output logic       alert,
    output logic       buzzer
);

    localparam int NUM_POS = 5;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW_W    = $clog2(DWELL_LIMIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_ALERT = 2'd2;

    // ------------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------------
    logic [NUM_POS-1:0] btn_raw_w;
    logic [NUM_POS-1:0] sync1_q;
    logic [NUM_POS-1:0] sync2_q;

    assign btn_raw_w = {seat_button, bar_button, tops_button, hoods_button, drops_button};

    // Two-flop synchroniser on every raw button before any other use
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw_w;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button debounce: a level is accepted only after DEBOUNCE_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    // ------------------------------------------------------------------------
    logic [NUM_POS-1:0] level_w;

    for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_d;
        logic            lvl_q;
        logic            lvl_d;

        // Next debounce count and level for this button
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync2_q[gi] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync2_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Debounce state register
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level_w[gi] = lvl_q;
    end

    // ------------------------------------------------------------------------
    // Grant selection: keep the current holder while it stays pressed,
    // otherwise pick the lowest-index pressed button (isolate lowest set bit).
    // ------------------------------------------------------------------------
    logic [NUM_POS-1:0] grant_q;
    logic [NUM_POS-1:0] grant_d;
    logic               pos_change_q;
    logic               grant_none_w;
    logic               grant_chg_w;

    // Sticky / lowest-index grant decision
    always_comb begin
        if ((grant_q & level_w) != '0) begin
            grant_d = grant_q;
        end else begin
            grant_d = level_w & (~level_w + NUM_POS'(1));
        end
    end

    assign grant_none_w = (grant_d == '0);
    assign grant_chg_w  = (grant_d != grant_q);

    // Registered grant and change pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q      <= '0;
            pos_change_q <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            pos_change_q <= grant_chg_w;
        end
    end

    assign BOARD_LEDs = grant_q;
    assign pos_change = pos_change_q;

    // ------------------------------------------------------------------------
    // Free-running dwell tick prescaler
    // ------------------------------------------------------------------------
    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic            tick_w;

    assign tick_w = (ps_q == PS_W'(TICK_DIV - 1));
    assign ps_d   = tick_w ? '0 : ps_q + 1'b1;

    // Prescaler counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // ------------------------------------------------------------------------
    // Dwell FSM
    // ------------------------------------------------------------------------
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [DW_W-1:0] dwell_q;
    logic [DW_W-1:0] dwell_d;

    // State and dwell counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Next state: a grant loss or change always clears dwell, even on a tick
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (!grant_none_w) begin
                    state_d = ST_HOLD;
                    dwell_d = '0;
                end
            end
            ST_HOLD, ST_ALERT: begin
                if (grant_none_w) begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                end else if (grant_chg_w) begin
                    state_d = ST_HOLD;
                    dwell_d = '0;
                end else if (tick_w && (dwell_q != DW_W'(DWELL_LIMIT))) begin
                    dwell_d = dwell_q + 1'b1;
                    if (dwell_q == DW_W'(DWELL_LIMIT - 1)) begin
                        state_d = ST_ALERT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        alert = (state_q == ST_ALERT);
    end

`ifdef POSITION_ARBITER_BUZZER_EN
    logic buzz_q;

    // Buzzer: set on ALERT entry, toggled on each later tick, cleared outside
    always_ff @(posedge clk) begin
        if (reset) begin
            buzz_q <= 1'b0;
        end else if (state_d != ST_ALERT) begin
            buzz_q <= 1'b0;
        end else if (state_q != ST_ALERT) begin
            buzz_q <= 1'b1;
        end else if (tick_w) begin
            buzz_q <= ~buzz_q;
        end
    end

    assign buzzer = buzz_q;
`else
    assign buzzer = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_position_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_position_arbiter
// Brief    : Directed self-checking bench for position_arbiter with
//            DEBOUNCE_CYCLES=4, TICK_DIV=2, DWELL_LIMIT=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_position_arbiter;

    localparam int DEB  = 4;
    localparam int TDIV = 2;
    localparam int DLIM = 5;

`ifdef POSITION_ARBITER_BUZZER_EN
    localparam logic BZ = 1'b1;
`else
    localparam logic BZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       drops_button, hoods_button, tops_button, bar_button, seat_button;
    logic [4:0] BOARD_LEDs;
    logic       pos_change, alert, buzzer;

    int checks   = 0;
    int failures = 0;
    int pc_count = 0;

    position_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV),
        .DWELL_LIMIT    (DLIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .drops_button(drops_button),
        .hoods_button(hoods_button),
        .tops_button (tops_button),
        .bar_button  (bar_button),
        .seat_button (seat_button),
        .BOARD_LEDs  (BOARD_LEDs),
        .pos_change  (pos_change),
        .alert       (alert),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    // Count pos_change pulses just after each rising edge
    always @(posedge clk) begin
        #1;
        if (pos_change === 1'b1) pc_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc0;
        int k;
        reset        = 1'b1;
        drops_button = 1'b0;
        hoods_button = 1'b0;
        tops_button  = 1'b0;
        bar_button   = 1'b0;
        seat_button  = 1'b0;
        cyc(3);
        check("rst_leds",   BOARD_LEDs, 5'b00000);
        check("rst_pc",     pos_change, 1'b0);
        check("rst_alert",  alert,      1'b0);
        check("rst_buzzer", buzzer,     1'b0);
        reset = 1'b0;
        cyc(2);

        // Clean press: 2 sync + 4 debounce + 1 register edges
        pc0 = pc_count;
        hoods_button = 1'b1;
        cyc(6);
        check("hoods_early", BOARD_LEDs, 5'b00000);
        cyc(1);
        check("hoods_leds", BOARD_LEDs, 5'b00010);
        check("hoods_pc",   pos_change, 1'b1);
        cyc(1);
        check("hoods_pc_end", pos_change, 1'b0);
        check("hoods_pc_cnt", pc_count - pc0, 1);
        hoods_button = 1'b0;
        cyc(8);
        check("hoods_rel", BOARD_LEDs, 5'b00000);

        // Three-cycle glitch is rejected
        pc0 = pc_count;
        hoods_button = 1'b1;
        cyc(3);
        hoods_button = 1'b0;
        cyc(10);
        check("glitch_leds",   BOARD_LEDs, 5'b00000);
        check("glitch_pc_cnt", pc_count - pc0, 0);

        // Sticky grant, then handover to lower index with dwell restart
        tops_button = 1'b1;
        cyc(7);
        check("tops_leds", BOARD_LEDs, 5'b00100);
        pc0 = pc_count;
        drops_button = 1'b1;
        cyc(10);
        check("sticky_leds",   BOARD_LEDs, 5'b00100);
        check("sticky_pc_cnt", pc_count - pc0, 0);
        tops_button = 1'b0;
        cyc(6);
        check("handover_early", BOARD_LEDs, 5'b00100);
        cyc(1);
        check("handover_leds",  BOARD_LEDs, 5'b00001);
        check("handover_pc",    pos_change, 1'b1);
        check("handover_alert", alert,      1'b0);
        check("handover_pc_cnt", pc_count - pc0, 1);
        cyc(8);
        check("dwell_restart", alert, 1'b0);
        drops_button = 1'b0;
        cyc(10);
        check("drops_rel", BOARD_LEDs, 5'b00000);

        // Dwell to alert, buzzer pattern, release
        seat_button = 1'b1;
        cyc(7);
        check("seat_leds", BOARD_LEDs, 5'b10000);
        cyc(8);
        check("seat_no_alert_yet", alert, 1'b0);
        k = 0;
        while (alert !== 1'b1 && k < 4) begin
            cyc(1);
            k++;
        end
        check("alert_rise",    alert, 1'b1);
        check("alert_latency", (k >= 1 && k <= 2), 1'b1);
        check("buzz_entry", buzzer, BZ);
        cyc(1);
        check("buzz_hold",  buzzer, BZ);
        cyc(1);
        check("buzz_tog1",  buzzer, 1'b0);
        cyc(2);
        check("buzz_tog2",  buzzer, BZ);
        seat_button = 1'b0;
        cyc(6);
        check("seat_rel_early", alert, 1'b1);
        cyc(1);
        check("seat_rel_leds",   BOARD_LEDs, 5'b00000);
        check("seat_rel_alert",  alert,      1'b0);
        check("seat_rel_buzzer", buzzer,     1'b0);
        check("seat_rel_pc",     pos_change, 1'b1);

        // Reset during ALERT with the button still held
        cyc(4);
        seat_button = 1'b1;
        k = 0;
        while (alert !== 1'b1 && k < 30) begin
            cyc(1);
            k++;
        end
        check("alert2_rise", alert, 1'b1);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_leds",   BOARD_LEDs, 5'b00000);
        check("mid_rst_pc",     pos_change, 1'b0);
        check("mid_rst_alert",  alert,      1'b0);
        check("mid_rst_buzzer", buzzer,     1'b0);
        reset = 1'b0;
        cyc(6);
        check("redeb_early", BOARD_LEDs, 5'b00000);
        cyc(1);
        check("redeb_leds",  BOARD_LEDs, 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
